// File: rtl/m3_sixsteppwmgen.sv
`default_nettype none
// ============================================================================
// Module   : m3_sixsteppwmgen
// Purpose  : Six-step (trapezoidal) commutation for a 3-phase bridge.
//            A divider-free phase accumulator advances the commutation step
//            six times per electrical round. PWM is applied to the high side,
//            the low side of the active low phase is held on, and every
//            phase has dead-time interlocking between its two gates.
// Ports    : clkI          system clock
//            nRstI         asynchronous active-low reset
//            workingI      motor enable; low forces every gate off
//            invRotateI    0 = forward step order, 1 = reverse
//            dstRoundLenI  clocks per electrical revolution (clamped low)
//            powerLevelI   high-side duty, latched at PWM period start
//            gAhO..gClO    registered high/low gate drives, phases A/B/C
//            stepIdxO      current commutation step 0..5
//            roundDoneO    one-clock pulse when the step wraps
// Revision : 1.0  initial release
// ============================================================================
module m3_sixsteppwmgen #(
  parameter int PWM_BITS  = 8,
  parameter int DEAD_CYC  = 4,
  parameter int MIN_ROUND = 6
) (
  input  logic                clkI,
  input  logic                nRstI,
  input  logic                workingI,
  input  logic                invRotateI,
  input  logic [31:0]         dstRoundLenI,
  input  logic [PWM_BITS-1:0] powerLevelI,
  output logic                gAhO,
  output logic                gAlO,
  output logic                gBhO,
  output logic                gBlO,
  output logic                gChO,
  output logic                gClO,
  output logic [2:0]          stepIdxO,
  output logic                roundDoneO
);

  localparam logic [3:0]  c_DEAD    = 4'(DEAD_CYC);
  localparam logic [31:0] c_MINLEN  = 32'(MIN_ROUND);
  localparam logic [2:0]  c_LASTSTP = 3'd5;

  logic [34:0]         r_acc;
  logic [2:0]          r_step;
  logic                r_roundDone;
  logic [PWM_BITS-1:0] r_pwmCnt;
  logic [PWM_BITS-1:0] r_powLat;
  logic [2:0]          r_gH;
  logic [2:0]          r_gL;

  logic [31:0] w_roundLen;
  logic [34:0] w_accInc;
  logic [34:0] w_roundLen35;
  logic        w_advance;
  logic [2:0]  w_nextStep;
  logic        w_wrap;
  logic        w_hiOn;
  logic [2:0]  w_hiMask;
  logic [2:0]  w_loMask;
  logic [2:0]  w_reqH;
  logic [2:0]  w_reqL;

  // Six accumulator units per clock against one round length means one
  // step per roundLen/6 clocks on average, with no divider and no drift.
  assign w_roundLen   = (dstRoundLenI < c_MINLEN) ? c_MINLEN : dstRoundLenI;
  assign w_roundLen35 = {3'b000, w_roundLen};
  assign w_accInc     = r_acc + 35'd6;
  assign w_advance    = (w_accInc >= w_roundLen35);

  always_comb begin
    w_nextStep = r_step;
    if (invRotateI) begin
      w_nextStep = (r_step == 3'd0) ? c_LASTSTP : r_step - 3'd1;
    end else begin
      w_nextStep = (r_step == c_LASTSTP) ? 3'd0 : r_step + 3'd1;
    end
  end

  // The wrap target is the first step of a new round in the current direction.
  assign w_wrap = invRotateI ? (w_nextStep == c_LASTSTP) : (w_nextStep == 3'd0);

  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      r_acc       <= '0;
      r_step      <= '0;
      r_roundDone <= 1'b0;
      r_pwmCnt    <= '0;
    end else if (!workingI) begin
      r_acc       <= '0;
      r_step      <= '0;
      r_roundDone <= 1'b0;
      r_pwmCnt    <= '0;
    end else begin
      r_pwmCnt <= r_pwmCnt + PWM_BITS'(1);
      if (w_advance) begin
        r_acc       <= w_accInc - w_roundLen35;
        r_step      <= w_nextStep;
        r_roundDone <= w_wrap;
      end else begin
        r_acc       <= w_accInc;
        r_roundDone <= 1'b0;
      end
    end
  end

  // Duty only changes at the start of a PWM period so no period is truncated.
  always_ff @(posedge clkI or negedge nRstI) begin
    if (!nRstI) begin
      r_powLat <= '0;
    end else if (r_pwmCnt == '0) begin
      r_powLat <= powerLevelI;
    end
  end

  assign w_hiOn = (r_pwmCnt < r_powLat);

  // Phase bit order: [0] = A, [1] = B, [2] = C.
  always_comb begin
    w_hiMask = 3'b000;
    w_loMask = 3'b000;
    case (r_step)
      3'd0:    begin w_hiMask = 3'b001; w_loMask = 3'b010; end
      3'd1:    begin w_hiMask = 3'b001; w_loMask = 3'b100; end
      3'd2:    begin w_hiMask = 3'b010; w_loMask = 3'b100; end
      3'd3:    begin w_hiMask = 3'b010; w_loMask = 3'b001; end
      3'd4:    begin w_hiMask = 3'b100; w_loMask = 3'b001; end
      3'd5:    begin w_hiMask = 3'b100; w_loMask = 3'b010; end
      default: begin w_hiMask = 3'b000; w_loMask = 3'b000; end
    endcase
  end

  assign w_reqH = w_hiOn ? w_hiMask : 3'b000;
  assign w_reqL = w_loMask;

  // A gate may only turn on once its complement has been off for DEAD_CYC
  // clocks. Requests of one phase are mutually exclusive, and a gate that was
  // on last clock holds its complement's counter at zero, so the two gates of
  // a phase can never be on together.
  for (genvar p = 0; p < 3; p++) begin : g_phase
    logic [3:0] r_offH;
    logic [3:0] r_offL;

    always_ff @(posedge clkI or negedge nRstI) begin
      if (!nRstI) begin
        r_gH[p] <= 1'b0;
        r_gL[p] <= 1'b0;
        r_offH  <= c_DEAD;
        r_offL  <= c_DEAD;
      end else begin
        r_gH[p] <= w_reqH[p] & (r_offL == c_DEAD) & workingI;
        r_gL[p] <= w_reqL[p] & (r_offH == c_DEAD) & workingI;
        r_offH  <= r_gH[p] ? 4'd0 : ((r_offH == c_DEAD) ? r_offH : r_offH + 4'd1);
        r_offL  <= r_gL[p] ? 4'd0 : ((r_offL == c_DEAD) ? r_offL : r_offL + 4'd1);
      end
    end
  end

  assign gAhO       = r_gH[0];
  assign gAlO       = r_gL[0];
  assign gBhO       = r_gH[1];
  assign gBlO       = r_gL[1];
  assign gChO       = r_gH[2];
  assign gClO       = r_gL[2];
  assign stepIdxO   = r_step;
  assign roundDoneO = r_roundDone;

endmodule
`default_nettype wire

// File: tb/tb_m3_sixsteppwmgen.sv
`default_nettype none
// ============================================================================
// Module   : tb_m3_sixsteppwmgen
// Purpose  : Self-checking bench for m3_sixsteppwmgen. Table of hand-computed
//            checkpoints for forward/reverse commutation, plus directed
//            sequences for fractional round length, fast stepping, duty
//            changes, enable drop and asynchronous reset. A negedge monitor
//            checks the shoot-through and dead-time invariants throughout.
// Revision : 1.0  initial release
// ============================================================================
module tb_m3_sixsteppwmgen;

  localparam int DEAD = 4;

  logic        clkI = 1'b0;
  logic        nRstI = 1'b0;
  logic        workingI = 1'b0;
  logic        invRotateI = 1'b0;
  logic [31:0] dstRoundLenI = 32'd0;
  logic [7:0]  powerLevelI = 8'd0;
  logic        gAhO, gAlO, gBhO, gBlO, gChO, gClO;
  logic [2:0]  stepIdxO;
  logic        roundDoneO;

  int total = 0;
  int bad   = 0;
  int ecnt  = 0;

  m3_sixsteppwmgen #(.PWM_BITS(8), .DEAD_CYC(DEAD), .MIN_ROUND(6)) dut (
    .clkI(clkI), .nRstI(nRstI), .workingI(workingI), .invRotateI(invRotateI),
    .dstRoundLenI(dstRoundLenI), .powerLevelI(powerLevelI),
    .gAhO(gAhO), .gAlO(gAlO), .gBhO(gBhO), .gBlO(gBlO), .gChO(gChO), .gClO(gClO),
    .stepIdxO(stepIdxO), .roundDoneO(roundDoneO)
  );

  always #5 clkI = ~clkI;

  function automatic logic [5:0] gates();
    return {gAhO, gAlO, gBhO, gBlO, gChO, gClO};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clkI);
    #1;
    ecnt++;
  endtask

  task automatic runTo(input int e);
    while (ecnt < e) tick();
  endtask

  // Holds reset for a few clocks, checks the reset state, then releases with
  // workingI high; the next rising edge is edge 1.
  task automatic doReset(input bit inv, input logic [31:0] len, input logic [7:0] pow);
    nRstI = 1'b0;
    workingI = 1'b0;
    invRotateI = inv;
    dstRoundLenI = len;
    powerLevelI = pow;
    repeat (5) tick();
    chk("reset gates", 32'(gates()), 32'd0);
    chk("reset step", 32'(stepIdxO), 32'd0);
    chk("reset done", 32'(roundDoneO), 32'd0);
    nRstI = 1'b1;
    workingI = 1'b1;
    ecnt = 0;
  endtask

  // Counts clocks with gAh high after edges from..to.
  task automatic countAh(input int from, input int to, output int cnt);
    runTo(from - 1);
    cnt = 0;
    while (ecnt < to) begin
      tick();
      if (gAhO) cnt++;
    end
  endtask

  // Shoot-through and dead-time monitor; bit pairs (5,4) (3,2) (1,0) are the
  // high/low gates of A, B, C.
  logic [5:0] mPrev = 6'd0;
  int         mOffRun[6] = '{100, 100, 100, 100, 100, 100};

  always @(negedge clkI) begin : monitor
    logic [5:0] g;
    g = gates();
    for (int p = 0; p < 3; p++) begin
      total++;
      if (g[2*p+1] && g[2*p]) begin
        bad++;
        $display("FAIL shoot-through phase %0d: gates %b expected not both on", p, g);
      end
    end
    for (int i = 0; i < 6; i++) begin
      if (g[i] && !mPrev[i]) begin
        total++;
        if (mOffRun[i ^ 1] < DEAD) begin
          bad++;
          $display("FAIL dead time gate bit %0d: complement off %0d clocks, expected >= %0d",
                   i, mOffRun[i ^ 1], DEAD);
        end
      end
    end
    for (int i = 0; i < 6; i++) mOffRun[i] = g[i] ? 0 : mOffRun[i] + 1;
    mPrev = g;
  end

  typedef struct {
    bit         rst;
    bit         inv;
    int         edgeN;
    logic [2:0] step;
    logic [5:0] gates;  // {Ah,Al,Bh,Bl,Ch,Cl}
    logic       done;
  } vec_t;

  vec_t vecs[20];

  initial begin
    int cnt, adv, firstAdv, lastAdv, badInt, noAdv;
    logic [2:0] prevStep;

    // Round length 600, power 128: one step per 100 clocks, gates lag a clock.
    vecs[0]  = '{1, 0,   1, 3'd0, 6'b000100, 1'b0};
    vecs[1]  = '{0, 0,   2, 3'd0, 6'b100100, 1'b0};
    vecs[2]  = '{0, 0,  99, 3'd0, 6'b100100, 1'b0};
    vecs[3]  = '{0, 0, 100, 3'd1, 6'b100100, 1'b0};
    vecs[4]  = '{0, 0, 101, 3'd1, 6'b100001, 1'b0};
    vecs[5]  = '{0, 0, 129, 3'd1, 6'b000001, 1'b0};
    vecs[6]  = '{0, 0, 200, 3'd2, 6'b000001, 1'b0};
    vecs[7]  = '{0, 0, 257, 3'd2, 6'b001001, 1'b0};
    vecs[8]  = '{0, 0, 301, 3'd3, 6'b011000, 1'b0};
    vecs[9]  = '{0, 0, 401, 3'd4, 6'b010000, 1'b0};
    vecs[10] = '{0, 0, 501, 3'd5, 6'b000100, 1'b0};
    vecs[11] = '{0, 0, 599, 3'd5, 6'b000110, 1'b0};
    vecs[12] = '{0, 0, 600, 3'd0, 6'b000110, 1'b1};
    vecs[13] = '{0, 0, 601, 3'd0, 6'b100100, 1'b0};
    // Reverse rotation.
    vecs[14] = '{1, 1,  99, 3'd0, 6'b100100, 1'b0};
    vecs[15] = '{0, 1, 100, 3'd5, 6'b100100, 1'b1};
    vecs[16] = '{0, 1, 101, 3'd5, 6'b000110, 1'b0};
    vecs[17] = '{0, 1, 200, 3'd4, 6'b000100, 1'b0};
    vecs[18] = '{0, 1, 600, 3'd0, 6'b100001, 1'b0};
    vecs[19] = '{0, 1, 700, 3'd5, 6'b000100, 1'b1};

    for (int i = 0; i < 20; i++) begin
      if (vecs[i].rst) doReset(vecs[i].inv, 32'd600, 8'd128);
      runTo(vecs[i].edgeN);
      chk($sformatf("vec%0d step", i), 32'(stepIdxO), 32'(vecs[i].step));
      chk($sformatf("vec%0d gates", i), 32'(gates()), 32'(vecs[i].gates));
      chk($sformatf("vec%0d done", i), 32'(roundDoneO), 32'(vecs[i].done));
    end

    // Round length 1000: 36 advances in 6000 clocks, steps of 166 or 167.
    doReset(0, 32'd1000, 8'd128);
    adv = 0; firstAdv = 0; lastAdv = 0; badInt = 0; prevStep = 3'd0;
    repeat (6000) begin
      tick();
      if (stepIdxO != prevStep) begin
        adv++;
        if (adv == 1) firstAdv = ecnt;
        else if ((ecnt - lastAdv) != 166 && (ecnt - lastAdv) != 167) badInt++;
        lastAdv = ecnt;
        prevStep = stepIdxO;
      end
    end
    chk("len1000 advances", 32'(adv), 32'd36);
    chk("len1000 first advance", 32'(firstAdv), 32'd167);
    chk("len1000 bad intervals", 32'(badInt), 32'd0);

    // Round length 0 clamps to 6: one advance every clock.
    doReset(0, 32'd0, 8'd200);
    noAdv = 0; prevStep = 3'd0;
    repeat (100) begin
      tick();
      if (stepIdxO == prevStep) noAdv++;
      prevStep = stepIdxO;
    end
    chk("len0 every clock", 32'(noAdv), 32'd0);
    dstRoundLenI = 32'd60;
    repeat (600) tick();

    // Duty change mid-period takes effect only at the next period start.
    doReset(0, 32'hFFFF_FFFF, 8'd64);
    runTo(100);
    powerLevelI = 8'd200;
    countAh(129, 256, cnt);
    chk("duty old tail", 32'(cnt), 32'd0);
    countAh(257, 512, cnt);
    chk("duty 200 count", 32'(cnt), 32'd200);
    powerLevelI = 8'd0;
    countAh(514, 1024, cnt);
    chk("duty 0 count", 32'(cnt), 32'd0);
    powerLevelI = 8'd255;
    countAh(1281, 1536, cnt);
    chk("duty 255 count", 32'(cnt), 32'd255);

    // workingI drop during step 3, restart at step 0.
    doReset(0, 32'd600, 8'd128);
    runTo(350);
    chk("pre-drop step", 32'(stepIdxO), 32'd3);
    workingI = 1'b0;
    runTo(351);
    chk("drop gates", 32'(gates()), 32'd0);
    chk("drop step", 32'(stepIdxO), 32'd0);
    runTo(360);
    workingI = 1'b1;
    runTo(361);
    chk("restart gates", 32'(gates()), 32'(6'b100100));
    runTo(459);
    chk("restart step 0", 32'(stepIdxO), 32'd0);
    runTo(460);
    chk("restart step 1", 32'(stepIdxO), 32'd1);

    // Asynchronous reset while the high side is on.
    runTo(470);
    chk("pre-reset gAh", 32'(gAhO), 32'd1);
    #2;
    nRstI = 1'b0;
    #1;
    chk("async reset gates", 32'(gates()), 32'd0);
    chk("async reset step", 32'(stepIdxO), 32'd0);
    repeat (5) tick();
    nRstI = 1'b1;
    repeat (5) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
